// File: rtl/crc16_serial_sched.sv
// crc16_serial_sched
//   Round-robin scheduler in front of one bit-serial CRC-16 engine
//   (MSB-first LFSR, non-reflected, no final XOR). Each accepted job
//   loads one DATA_W-bit word, shifts it through the LFSR one bit per
//   clock, and returns the 16-bit result with the requester's index.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   req        per-requester job request, held until its gnt bit pulses
//   req_data   job words, requester i at [i*DATA_W +: DATA_W]
//   gnt        one-hot single-cycle acceptance; the word is captured then
//   busy       engine occupied (SHIFT or DONE)
//   crc_valid  result available
//   crc_ready  result consumer ready
//   crc_out    CRC result, qualified by crc_valid
//   crc_id     requester index belonging to crc_out
module crc16_serial_sched #(
  parameter int          NREQ   = 4,
  parameter int          DATA_W = 32,
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     crc_valid,
  input  logic                     crc_ready,
  output logic [15:0]              crc_out,
  output logic [$clog2(NREQ)-1:0]  crc_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [IDW-1:0]    ptr;
  logic [CW-1:0]     cnt;
  logic [15:0]       lfsr;
  logic [DATA_W-1:0] word;

  logic [DATA_W-1:0] words [NREQ];
  logic              found;
  logic [IDW-1:0]    win;
  logic [IDW-1:0]    cand;
  int unsigned       pos;
  logic              fb;
  logic [15:0]       lfsr_nxt;
  logic              last;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      words[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // First set request at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = 0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = k + 32'(ptr);
      if (pos >= NREQ) pos = pos - NREQ;
      cand = IDW'(pos);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // The word register shifts left each cycle, so its MSB is always
  // word[DATA_W-1-cnt] of the originally captured value.
  always_comb begin
    fb       = lfsr[15] ^ word[DATA_W-1];
    lfsr_nxt = {lfsr[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    last     = (cnt == CW'(DATA_W - 1));
  end

  // gnt is registered, so a grant takes two IDLE cycles: the decision
  // cycle raises gnt, and the gnt cycle itself captures the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      crc_valid <= 1'b0;
      crc_out   <= '0;
      crc_id    <= '0;
      ptr       <= '0;
      cnt       <= '0;
      lfsr      <= INIT;
      word      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt != '0) begin
            word  <= words[crc_id];
            lfsr  <= INIT;
            cnt   <= '0;
            gnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else if (found) begin
            gnt    <= NREQ'(1) << win;
            crc_id <= win;
            ptr    <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
          end
        end
        SHIFT: begin
          lfsr <= lfsr_nxt;
          word <= word << 1;
          cnt  <= cnt + CW'(1);
          if (last) begin
            crc_out   <= lfsr_nxt;
            crc_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (crc_ready) begin
            crc_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_serial_sched.sv
// Testbench for crc16_serial_sched: directed scenarios followed by a
// randomized phase; a grant/timing model and a result scoreboard check
// the DUT on every falling clock edge.
module tb_crc16_serial_sched;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           crc_valid;
  logic           crc_ready;
  logic [15:0]    crc_out;
  logic [IDW-1:0] crc_id;

  always #5 clk = ~clk;

  crc16_serial_sched #(
    .NREQ  (N),
    .DATA_W(W),
    .POLY  (16'h1021),
    .INIT  (16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .busy     (busy),
    .crc_valid(crc_valid),
    .crc_ready(crc_ready),
    .crc_out  (crc_out),
    .crc_id   (crc_id)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] crc;
    int          id;
  } exp_t;
  exp_t sb[$];

  // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] crc_ref(input logic [31:0] w);
    logic [47:0] r;
    r = {w, 16'h0000};
    for (int i = 47; i >= 16; i--) begin
      if (r[i]) r = r ^ (48'h11021 << (i - 16));
    end
    return r[15:0];
  endfunction

  function automatic int winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the scheduler's externally visible timing.
  int           cyc = 0;
  int           gcyc = 0;
  int           mptr = 0;
  bit           outstanding = 1'b0;
  bit           idle_prev = 1'b1;
  bit           exp_g;
  bit           exp_v;
  bit           hs;
  int           w;
  exp_t         e;
  logic [N-1:0] req_prev = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      outstanding = 1'b0;
      idle_prev   = 1'b1;
      req_prev    = '0;
      mptr        = 0;
    end else begin
      exp_g = idle_prev && (req_prev != '0);
      exp_v = outstanding && ((cyc - gcyc) >= W + 1);
      check("busy", busy, outstanding && ((cyc - gcyc) >= 1));
      check("crc_valid", crc_valid, exp_v);
      check("gnt_present", gnt != '0, exp_g);
      if (exp_g) begin
        w = winner(req_prev, mptr);
        check("gnt_winner", gnt, 32'(1) << w);
        e.crc = crc_ref(req_data[w*W +: W]);
        e.id  = w;
        sb.push_back(e);
        mptr        = (w + 1) % N;
        outstanding = 1'b1;
        gcyc        = cyc;
      end
      hs = exp_v && crc_ready;
      if (hs) outstanding = 1'b0;
      idle_prev = !outstanding && !hs && !exp_g;
      req_prev  = req;
    end
  end

  // Result monitor: every presented result must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && crc_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL result_unexpected: got crc 0x%0h id %0d, expected no result", crc_out, crc_id);
      end else begin
        check("crc_out", crc_out, sb[0].crc);
        check("crc_id", crc_id, sb[0].id);
        if (crc_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req = req & ~gnt;
  endtask

  task automatic issue(input int i, input logic [31:0] wd);
    if (!req[i] && !gnt[i]) begin
      req_data[i*W +: W] = wd;
      req[i] = 1'b1;
    end
  endtask

  task automatic wait_gnt(output logic [N-1:0] g);
    g = '0;
    for (int k = 0; k < 300 && g == '0; k++) begin
      step();
      g = gnt;
    end
    if (g == '0) begin
      tests++;
      fails++;
      $display("FAIL gnt_timeout: got no grant, expected one within 300 cycles");
    end
  endtask

  task automatic wait_result(input logic [15:0] c, input int id);
    int k;
    k = 0;
    while (!crc_valid && k < 300) begin
      step();
      k++;
    end
    if (!crc_valid) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: got no crc_valid, expected one within 300 cycles");
    end else begin
      check("direct_crc", crc_out, c);
      check("direct_id", crc_id, id);
      step();
    end
  endtask

  task automatic drain();
    int k;
    req = '0;
    k = 0;
    while ((busy || crc_valid || gnt != '0) && k < 400) begin
      step();
      k++;
    end
    if (busy || crc_valid) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got busy=%0b valid=%0b, expected idle", busy, crc_valid);
    end
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  function automatic logic [31:0] pattern();
    case ($urandom_range(0, 3))
      0:       return 32'(1) << $urandom_range(0, 31);
      1:       return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
      default: return $urandom;
    endcase
  endfunction

  logic [N-1:0] g;
  int           k;

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_data  = '0;
    crc_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", crc_valid, 0);
    check("rst_crc_out", crc_out, 0);
    check("rst_crc_id", crc_id, 0);
    step();
    rst = 1'b0;
    step();

    // Known-answer jobs.
    issue(0, 32'h0);
    wait_gnt(g);
    check("gnt_zero_job", g, 4'b0001);
    wait_result(16'h0000, 0);
    issue(2, 32'h1);
    wait_gnt(g);
    check("gnt_req2", g, 4'b0100);
    wait_result(16'h1021, 2);
    issue(2, 32'h2);
    wait_gnt(g);
    wait_result(16'h2042, 2);
    drain();

    // All requesters continuously asserting: rotation from pointer 0.
    do_reset();
    for (int i = 0; i < N; i++) issue(i, $urandom);
    repeat (6 * 35 + 3) begin
      step();
      for (int i = 0; i < N; i++) issue(i, $urandom);
    end
    drain();

    // Backpressure held in DONE while another request waits.
    issue(0, $urandom);
    k = 0;
    while (!crc_valid && k < 300) begin
      step();
      k++;
    end
    crc_ready = 1'b0;
    issue(1, $urandom);
    repeat (10) step();
    crc_ready = 1'b1;
    wait_gnt(g);
    check("gnt_after_backpressure", g, 4'b0010);
    drain();

    // Reset in the middle of shifting discards the job.
    issue(0, $urandom);
    wait_gnt(g);
    repeat (11) step();
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", crc_valid, 0);
    check("midrst_gnt", gnt, 0);
    req = '0;
    issue(1, $urandom);
    issue(2, $urandom);
    step();
    step();
    rst = 1'b0;
    wait_gnt(g);
    check("gnt_after_reset", g, 4'b0010);
    drain();

    // Pointer wrap from requester 3 back to 0.
    issue(3, $urandom);
    wait_gnt(g);
    check("gnt_req3", g, 4'b1000);
    step();
    issue(0, $urandom);
    issue(3, $urandom);
    wait_gnt(g);
    check("gnt_wrap", g, 4'b0001);
    drain();

    // Randomized traffic with random backpressure and withdrawn requests.
    repeat (3000) begin
      step();
      crc_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) < 3) issue(i, pattern());
        else if (req[i] && $urandom_range(0, 49) == 0) req[i] = 1'b0;
      end
    end
    crc_ready = 1'b1;
    drain();
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crc16_serial_sched.md
Name: crc16_serial_sched

Overview:
- Round-robin scheduler wrapped around a bit-serial CRC-16 engine (CCITT polynomial, MSB-first).
- Shares one engine among NREQ requesters. Each grant loads one DATA_W-bit word, shifts it through the LFSR one bit per clock, and returns the 16-bit result with a tag on a valid/ready result port.
- Sits between word-level producers and the serial CRC datapath. It replaces free-running, counter-driven CRC shifting with on-demand, arbitrated jobs.

Parameters:
- NREQ, 4, number of requesters (≥2).
- DATA_W, 32, bits per job word (≥1); shift counter width is clog2(DATA_W+1).
- POLY, 16'h1021, CRC feedback polynomial (x^16 implicit).
- INIT, 16'h0000, LFSR seed loaded at each grant.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester job request; held high until the matching gnt bit pulses.
- req_data  in  NREQ*DATA_W  job words; requester i occupies bits [i*DATA_W +: DATA_W]; must be stable while req[i]=1.
- gnt  out  NREQ  one-hot, single-cycle acceptance pulse; data is captured on this cycle.
- busy  out  1  high in SHIFT and DONE.
- crc_valid  out  1  result available.
- crc_ready  in  1  result consumer ready.
- crc_out  out  16  CRC result.
- crc_id  out  clog2(NREQ)  index of the requester the result belongs to.

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, busy=0, crc_valid=0, crc_out=0, crc_id=0, round-robin pointer=0, shift counter=0, LFSR=INIT. A job in progress is discarded and never reported.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - If any req bit is high, choose the first set bit scanning from the pointer upward with wrap.
  - Pulse gnt[i] for that cycle only; latch req_data[i] into the shift register and i into crc_id.
  - Load LFSR=INIT, set counter=0, set pointer=(i+1) mod NREQ, go to SHIFT.
  - If no req bit is high, stay in IDLE with gnt=0.
- SHIFT: once per cycle:
  - b = word[DATA_W-1-cnt]; fb = lfsr[15]^b.
  - lfsr = {lfsr[14:0],1'b0} ^ (fb ? POLY : 0); cnt++.
  - After the cycle that processes cnt=DATA_W-1, go to DONE.
  - SHIFT lasts exactly DATA_W cycles.
- DONE:
  - crc_valid=1; crc_out=lfsr; crc_id held.
  - crc_out and crc_id stay stable while crc_valid=1 and crc_ready=0.
  - On crc_valid&crc_ready, go to IDLE; crc_valid drops next cycle.
  - crc_out keeps its last value after the handshake; only crc_valid qualifies it.
- Latency:
  - gnt at cycle T gives crc_valid at T+DATA_W+1.
  - With crc_ready tied high, the next gnt comes no earlier than T+DATA_W+3.
- No grant is issued in SHIFT or DONE; req bits there are ignored and remain pending.
- A requester dropping req before its grant loses its turn silently; no error is flagged.
- Simultaneous requests are resolved only by the pointer. A requester continuously asserting req is served at most once per NREQ grants when others are also requesting.
- A reset that overlaps a handshake cycle wins: no result is delivered.
- crc_out equals the non-reflected, no-final-XOR CRC-16/XMODEM of the word, MSB first (when INIT=0).

Test Plan:
- Data zero: after reset, req[0]=1, word 0x00000000 → gnt=4'b0001 for one cycle; crc_valid rises exactly 33 cycles later; crc_out=0x0000, crc_id=0.
- Single set bits: req[2] word 0x00000001 → crc_out=0x1021, crc_id=2. A following job on req[2] with word 0x00000002 → crc_out=0x2042.
- Fairness: req=4'b1111 held with crc_ready=1 → grant order 0,1,2,3,0,1; gnt is always one-hot; successive grants are exactly 35 cycles apart.
- Backpressure: hold crc_ready=0 for 10 cycles in DONE → crc_valid, crc_out and crc_id stay stable, no gnt while req[1]=1. Raise crc_ready → handshake, and gnt[1] follows two cycles later.
- Reset mid-job: assert rst when cnt=10 → busy, crc_valid and gnt go 0 immediately and no result appears. After release with req=4'b0110, the first grant goes to requester 1 (pointer reset to 0).
- Pointer wrap: grant requester 3, then present req=4'b1001 → next grant goes to requester 0, not 3.
